// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared FSM state encoding and default parameters for mac_array
// Revision    : 1.0
// ============================================================================
package mac_pkg;

    localparam int c_N_LANES  = 4;
    localparam int c_DATA_W   = 8;
    localparam int c_WEIGHT_W = 8;
    localparam int c_ACC_W    = 32;
    localparam int c_LEN_W    = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : mac_lane
// Description : One MAC lane - registered signed product, then accumulate
//               with wrap or saturate and a sticky overflow flag
// Revision    : 1.0
// ============================================================================
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int WEIGHT_W = c_WEIGHT_W,
    parameter int ACC_W    = c_ACC_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_zero,
    input  logic                i_beat,
    input  logic                i_sat,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [WEIGHT_W-1:0] i_weight,
    output logic [ACC_W-1:0]    o_acc,
    output logic                o_ovf
);

    localparam int c_PROD_W = DATA_W + WEIGHT_W;
    localparam logic [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [DATA_W-1:0]   w_data;
    logic signed [WEIGHT_W-1:0] w_weight;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W:0]      w_sum;
    logic                       w_of;
    logic signed [ACC_W-1:0]    w_next;

    logic signed [c_PROD_W-1:0] r_prod;
    logic                       r_pvld;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_ovf;

    assign w_data   = i_data;
    assign w_weight = i_weight;
    assign w_prod   = c_PROD_W'(w_data) * c_PROD_W'(w_weight);

    // One guard bit: a mismatch between the two top bits is a signed overflow,
    // and the guard bit itself gives the true sign for choosing the clamp rail.
    assign w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_prod);
    assign w_of  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_next = w_sum[ACC_W-1:0];
        if (w_of && i_sat) begin
            w_next = w_sum[ACC_W] ? c_MIN : c_MAX;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prod <= '0;
            r_pvld <= 1'b0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else if (i_zero) begin
            r_prod <= '0;
            r_pvld <= 1'b0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pvld <= i_beat;
            if (i_beat) begin
                r_prod <= w_prod;
            end
            if (r_pvld) begin
                r_acc <= w_next;
                r_ovf <= r_ovf | w_of;
            end
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule : mac_lane
`default_nettype wire

// File: rtl/mac_array.sv
`default_nettype none
// ============================================================================
// Module      : mac_array
// Description : N-lane signed multiply-accumulate array with run-length FSM,
//               input/output handshakes and wrap/saturate modes
// Revision    : 1.0
// ============================================================================
module mac_array
    import mac_pkg::*;
#(
    parameter int N_LANES  = c_N_LANES,
    parameter int DATA_W   = c_DATA_W,
    parameter int WEIGHT_W = c_WEIGHT_W,
    parameter int ACC_W    = c_ACC_W,
    parameter int LEN_W    = c_LEN_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [LEN_W-1:0]            len_i,
    input  logic                        sat_en_i,
    input  logic                        clear_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [N_LANES*DATA_W-1:0]   in_data_i,
    input  logic [N_LANES*WEIGHT_W-1:0] in_weight_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [N_LANES*ACC_W-1:0]    out_data_o,
    output logic [N_LANES-1:0]          ovf_o,
    output logic                        busy_o
);

    generate
        if (ACC_W < DATA_W + WEIGHT_W) begin : g_acc_w_check
            $error("mac_array: ACC_W must be >= DATA_W + WEIGHT_W");
        end
    endgenerate

    state_e             r_state;
    state_e             w_next_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_sat;
    logic               r_drain;

    logic               w_start_ok;
    logic               w_accept;
    logic               w_last;
    logic               w_lane_zero;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;

    logic [N_LANES-1:0][ACC_W-1:0] w_acc;
    logic [N_LANES-1:0]            w_ovf;

    // clear_i dominates both a new start and any beat offered in the same cycle.
    assign w_start_ok  = (r_state == S_IDLE) && start_i && (len_i != '0) && !clear_i;
    assign w_accept    = (r_state == S_ACCUM) && in_valid_i && !clear_i;
    assign w_last      = w_accept && ((r_cnt + LEN_W'(1)) == r_len);
    assign w_lane_zero = w_start_ok || clear_i;

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_start_ok) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                if (w_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (clear_i) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Two DRAIN cycles let the last product pass both lane stages.
            r_drain <= (r_state == S_DRAIN) && !r_drain && !clear_i;
            if (w_start_ok) begin
                r_len <= len_i;
                r_sat <= sat_en_i;
            end
            if (w_lane_zero) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < N_LANES; g++) begin : g_lane
            mac_lane #(
                .DATA_W   (DATA_W),
                .WEIGHT_W (WEIGHT_W),
                .ACC_W    (ACC_W)
            ) u_lane (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .i_zero   (w_lane_zero),
                .i_beat   (w_accept),
                .i_sat    (r_sat),
                .i_data   (in_data_i[g*DATA_W +: DATA_W]),
                .i_weight (in_weight_i[g*WEIGHT_W +: WEIGHT_W]),
                .o_acc    (w_acc[g]),
                .o_ovf    (w_ovf[g])
            );

            assign out_data_o[g*ACC_W +: ACC_W] = w_out_valid ? w_acc[g] : '0;
        end
    endgenerate

    assign ovf_o       = w_ovf;
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign busy_o      = w_busy;

endmodule : mac_array
`default_nettype wire

// File: tb/tb_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_array
// Description : Directed self-checking bench for mac_array (32- and 16-bit acc)
// Revision    : 1.0
// ============================================================================
module tb_mac_array;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int WW   = 8;
    localparam int AW   = 32;
    localparam int AW16 = 16;
    localparam int LW   = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   len = '0;
    logic            sat = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic [N*WW-1:0] in_weight = '0;
    logic            out_ready = 1'b0;

    logic              in_ready, out_valid, busy;
    logic [N*AW-1:0]   out_data;
    logic [N-1:0]      ovf;
    logic              in_ready16, out_valid16, busy16;
    logic [N*AW16-1:0] out_data16;
    logic [N-1:0]      ovf16;

    int n_assert = 0;
    int n_fail   = 0;
    int wait_k;

    always #5 clk = ~clk;

    mac_array u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .sat_en_i(sat),
        .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_weight_i(in_weight), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .ovf_o(ovf), .busy_o(busy)
    );

    mac_array #(.ACC_W(AW16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .sat_en_i(sat),
        .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready16),
        .in_data_i(in_data), .in_weight_i(in_weight), .out_valid_o(out_valid16),
        .out_ready_i(out_ready), .out_data_o(out_data16), .ovf_o(ovf16), .busy_o(busy16)
    );

    function automatic logic [31:0] lane(input int n);
        return out_data[n*AW +: AW];
    endfunction

    function automatic logic [31:0] lane16(input int n);
        return {16'h0000, out_data16[n*AW16 +: AW16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int d0, input int w0, input int dx, input int wx);
        in_data   = {DW'(dx), DW'(dx), DW'(dx), DW'(d0)};
        in_weight = {WW'(wx), WW'(wx), WW'(wx), WW'(w0)};
    endtask

    task automatic do_start(input int l, input logic s);
        start = 1'b1;
        len   = LW'(l);
        sat   = s;
        step();
        start = 1'b0;
    endtask

    task automatic send_beat(input int d0, input int w0, input int dx, input int wx);
        set_beat(d0, w0, dx, wx);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        wait_k = 0;
        while (!out_valid && wait_k < 20) begin
            step();
            wait_k++;
        end
        chk({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk(tag, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", out_data[31:0] | out_data[127:96], 32'd0);
        chk("rst_ovf", {28'd0, ovf}, 32'd0);
        rst = 1'b0;
        step();

        // Basic run, latency of exactly 3 cycles after the last beat
        do_start(3, 1'b0);
        chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        send_beat(1, 2, -1, 1);
        send_beat(3, 4, -1, 1);
        send_beat(5, 6, -1, 1);
        chk("basic_lat1_valid", {31'd0, out_valid}, 32'd0);
        chk("basic_drain_ready", {31'd0, in_ready}, 32'd0);
        chk("basic_drain_data0", lane(0), 32'd0);
        step();
        chk("basic_lat2_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("basic_lat3_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_lane0", lane(0), 32'd44);
        chk("basic_lane1", lane(1), -32'sd3);
        chk("basic_lane3", lane(3), -32'sd3);
        chk("basic_ovf", {28'd0, ovf}, 32'd0);
        release_out("basic_release");
        chk("basic_idle_data", lane(0), 32'd0);
        chk("basic_idle_busy", {31'd0, busy}, 32'd0);

        // Overflow: saturate mode
        do_start(4, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(-128, -128, -128, -128);
        wait_valid("sat");
        chk("sat16_valid", {31'd0, out_valid16}, 32'd1);
        chk("sat16_lane0", lane16(0), 32'h0000_7FFF);
        chk("sat16_lane2", lane16(2), 32'h0000_7FFF);
        chk("sat16_ovf", {28'd0, ovf16}, 32'hF);
        chk("sat32_lane0", lane(0), 32'd65536);
        chk("sat32_ovf", {28'd0, ovf}, 32'd0);
        release_out("sat_release");

        // Overflow: wrap mode
        do_start(4, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(-128, -128, -128, -128);
        wait_valid("wrap");
        chk("wrap16_lane0", lane16(0), 32'd0);
        chk("wrap16_ovf", {28'd0, ovf16}, 32'hF);
        chk("wrap32_lane1", lane(1), 32'd65536);
        release_out("wrap_release");

        // Gaps on input, backpressure on output
        do_start(5, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            send_beat(k, k + 1, 2, -3);
            step();
        end
        wait_valid("gap");
        chk("gap_lane0", lane(0), 32'd70);
        chk("gap_lane1", lane(1), -32'sd30);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_lane0", lane(0), 32'd70);
        end
        release_out("bp_release");
        step();
        chk("bp_single_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_single_busy", {31'd0, busy}, 32'd0);

        // Abort with clear_i after two of four beats
        do_start(4, 1'b0);
        send_beat(1, 1, 1, 1);
        send_beat(1, 1, 1, 1);
        set_beat(1, 1, 1, 1);
        in_valid = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("clr_ovf", {28'd0, ovf}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("clr_no_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        do_start(1, 1'b0);
        send_beat(7, 3, 0, 0);
        wait_valid("post_clr");
        chk("post_clr_lane0", lane(0), 32'd21);
        chk("post_clr_lane2", lane(2), 32'd0);
        release_out("post_clr_release");

        // Illegal starts
        do_start(0, 1'b0);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        step();
        chk("len0_busy2", {31'd0, busy}, 32'd0);
        do_start(2, 1'b0);
        start = 1'b1;
        len = LW'(1);
        send_beat(2, 3, 1, 1);
        start = 1'b0;
        send_beat(4, 5, 1, 1);
        wait_valid("midstart");
        chk("midstart_lane0", lane(0), 32'd26);
        chk("midstart_lane1", lane(1), 32'd2);
        release_out("midstart_release");
        start = 1'b1;
        len = LW'(3);
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        chk("startclr_busy", {31'd0, busy}, 32'd0);
        chk("startclr_ready", {31'd0, in_ready}, 32'd0);

        // Asynchronous reset in DRAIN
        do_start(2, 1'b0);
        send_beat(3, 3, 3, 3);
        send_beat(3, 3, 3, 3);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_ovf", {28'd0, ovf}, 32'd0);
        chk("arst_data", lane(0), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_start(2, 1'b0);
        send_beat(-4, 5, 1, 1);
        send_beat(6, -2, 1, 1);
        wait_valid("post_rst");
        chk("post_rst_lane0", lane(0), -32'sd32);
        chk("post_rst_lane3", lane(3), 32'd2);
        release_out("post_rst_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mac_array
`default_nettype wire

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 Parameter N_LANES, default 4, number of parallel MAC lanes.
REQ-002 Parameter DATA_W, default 8, signed input-operand width.
REQ-003 Parameter WEIGHT_W, default 8, signed weight-operand width.
REQ-004 Parameter ACC_W, default 32, signed accumulator/result width; SHALL be >= DATA_W+WEIGHT_W, with an elaboration error otherwise.
REQ-005 Parameter LEN_W, default 10, width of the vector-length field.
REQ-006 Clocking SHALL be one clock and reset SHALL be asynchronous and active-high.
REQ-007 clk_i  in  1  rising-edge clock.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 start_i  in  1  single-cycle pulse that begins an accumulation run.
REQ-010 len_i  in  LEN_W  beats per run, sampled with start_i.
REQ-011 sat_en_i  in  1  saturation mode (1) or wrap mode (0), sampled with start_i.
REQ-012 clear_i  in  1  synchronous abort.
REQ-013 in_valid_i / in_ready_o  in/out  1  input beat handshake.
REQ-014 in_data_i  in  N_LANES*DATA_W  packed signed operands, lane 0 in the LSBs.
REQ-015 in_weight_i  in  N_LANES*WEIGHT_W  packed signed weights, lane 0 in the LSBs.
REQ-016 out_valid_o / out_ready_i  out/in  1  result handshake.
REQ-017 out_data_o  out  N_LANES*ACC_W  packed signed lane results.
REQ-018 ovf_o  out  N_LANES  per-lane sticky overflow flag for the current result.
REQ-019 busy_o  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, ACCUM, DRAIN, DONE.
REQ-021 IDLE: a start_i with len_i != 0 SHALL latch len_i and sat_en_i, zero all accumulators and ovf_o, and go to ACCUM; a start_i with len_i == 0 SHALL be ignored.
REQ-022 ACCUM: in_ready_o = 1; a beat is accepted on each cycle with in_valid_i & in_ready_o; gaps in in_valid_i SHALL be tolerated.
REQ-023 ACCUM SHALL go to DRAIN in the cycle after the len-th beat is accepted; in_ready_o SHALL be 0 in every state other than ACCUM.
REQ-024 Lane pipeline: stage 1 registers the full-width signed product; stage 2 sign-extends the product to ACC_W and adds it to the accumulator.
REQ-025 DRAIN SHALL last exactly 2 cycles, then go to DONE.
REQ-026 out_valid_o SHALL rise exactly 3 cycles after the cycle in which the last beat is accepted.
REQ-027 DONE: out_valid_o = 1; out_data_o and ovf_o SHALL stay stable until out_valid_o & out_ready_i; on that cycle the FSM SHALL go to IDLE.
REQ-028 Wrap mode: accumulation SHALL wrap as two's complement; ovf_o[n] SHALL be set on signed overflow of lane n.
REQ-029 Saturation mode: lane n SHALL clamp to +(2^(ACC_W-1))-1 or -2^(ACC_W-1) and set ovf_o[n]; a clamped lane SHALL stay clamped only while further products push it out of range.
REQ-030 start_i outside IDLE SHALL be ignored.
REQ-031 clear_i SHALL send any state to IDLE on the next edge, zero the accumulators, ovf_o and the beat counter, and drop out_valid_o; a beat presented on the clear_i cycle SHALL be discarded.
REQ-032 If clear_i and start_i are asserted together, clear_i SHALL win and the start SHALL be lost.
REQ-033 out_data_o SHALL read 0 whenever out_valid_o = 0.

Reset
REQ-034 While rst_i is high: state = IDLE; in_ready_o, out_valid_o, busy_o = 0; out_data_o, ovf_o, accumulators, pipeline registers and beat counter = 0.
REQ-035 Reset asserted mid-run SHALL abort the run with no output; after release, the first start_i SHALL begin a clean run.

Structure
REQ-036 Shared package mac_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-037 Sub-module mac_lane (product register, accumulator, saturation/overflow logic) SHALL be instantiated N_LANES times by a generate loop; mac_array SHALL hold the FSM, beat counter and handshakes.

Verification (defaults unless stated)
REQ-038 Basic run: len=3; lane0 beats (1,2),(3,4),(5,6) back-to-back; other lanes (-1,1) -> lane0=44, other lanes=-3; out_valid_o rises 3 cycles after the third beat.
REQ-039 Overflow, ACC_W=16, len=4, every beat (-128,-128): sat_en=1 -> 32767, ovf=1; sat_en=0 -> 0 (wrapped), ovf=1.
REQ-040 Gaps and backpressure: len=5 with in_valid_i toggling every cycle; out_ready_i held low for 5 cycles after out_valid_o -> out_data_o stable throughout, sum correct, single completion.
REQ-041 Abort: clear_i after the 2nd of 4 beats -> IDLE next cycle, no out_valid_o; then a new len=1 run of (7,3) -> 21.
REQ-042 Illegal starts: start with len=0 -> stays IDLE; start during ACCUM -> ignored, result unchanged; start+clear in IDLE -> stays IDLE.
REQ-043 Reset: rst_i pulsed in DRAIN -> all outputs 0 immediately; the next run produces the correct result.
